param_fifo: RTL

Parametrised synchronous FIFO; successor to the fixed 16-bit, 8-entry buffer. Adds configurable data width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and defined simultaneous read/write behaviour at the full and empty boundaries. It sits between a producer and a consumer in the same clock domain. Examples are stream buffering ahead of the LED/7-seg display logic and the UART TX path.

---
 rtl/param_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with registered read data,
// occupancy count, programmable almost-full/almost-empty thresholds,
// synchronous flush and overflow/underflow pulses.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   CLR          synchronous flush (pointers, count and outputs to reset values)
//   DIN/WR       write data / write request
//   RD           read request
//   DOUT/VALID   registered read data / one-cycle pulse on an accepted read
//   FULL/EMPTY   COUNT == DEPTH / COUNT == 0
//   almostFULL   COUNT >= AF_LEVEL
//   almostEMPTY  COUNT <= AE_LEVEL
//   OVER/UNDER   one-cycle pulse: write / read rejected
//   COUNT        occupancy, 0..DEPTH
module param_fifo #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             WR,
  input  logic             RD,
  output logic [WIDTH-1:0] DOUT,
  output logic             VALID,
  output logic             FULL,
  output logic             EMPTY,
  output logic             almostFULL,
  output logic             almostEMPTY,
  output logic             OVER,
  output logic             UNDER,
  output logic [AW:0]      COUNT
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             rd_ok;
  logic             wr_ok;
  logic [AW:0]      cnt_nxt;

  // A read frees a slot on the same edge, so a full FIFO still accepts a
  // simultaneous write; an empty FIFO never forwards a same-cycle write.
  always_comb begin
    rd_ok = RD & ~EMPTY;
    wr_ok = WR & (~FULL | rd_ok);
  end

  always_comb begin
    cnt_nxt = COUNT;
    if (wr_ok && !rd_ok)
      cnt_nxt = COUNT + 1'b1;
    else if (rd_ok && !wr_ok)
      cnt_nxt = COUNT - 1'b1;
  end

  // Storage carries no reset; stale words are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge CLK) begin
    if (wr_ok && !CLR)
      mem[wptr] <= DIN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr        <= '0;
      rptr        <= '0;
      COUNT       <= '0;
      DOUT        <= '0;
      VALID       <= 1'b0;
      FULL        <= 1'b0;
      EMPTY       <= 1'b1;
      almostFULL  <= 1'b0;
      almostEMPTY <= 1'b1;
      OVER        <= 1'b0;
      UNDER       <= 1'b0;
    end else if (CLR) begin
      wptr        <= '0;
      rptr        <= '0;
      COUNT       <= '0;
      DOUT        <= '0;
      VALID       <= 1'b0;
      FULL        <= 1'b0;
      EMPTY       <= 1'b1;
      almostFULL  <= 1'b0;
      almostEMPTY <= 1'b1;
      OVER        <= 1'b0;
      UNDER       <= 1'b0;
    end else begin
      if (wr_ok)
        wptr <= wptr + 1'b1;
      if (rd_ok) begin
        DOUT <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      COUNT       <= cnt_nxt;
      VALID       <= rd_ok;
      OVER        <= WR & ~wr_ok;
      UNDER       <= RD & ~rd_ok;
      // Flags are derived from the next count so they agree with COUNT
      // after the same edge.
      FULL        <= (cnt_nxt == DEPTH_C);
      EMPTY       <= (cnt_nxt == '0);
      almostFULL  <= (cnt_nxt >= AF_C);
      almostEMPTY <= (cnt_nxt <= AE_C);
    end
  end

endmodule
